struct_unpacker: RTL and testbench

Downstream consumer of the 4-bit packed pair word `{last[1:0], first[1:0]}` that the struct-assembling stage produces on its `result` bus. The block buffers these words in a small FIFO and emits each one as two 2-bit beats on a valid/ready stream: `first` goes out first, then `last` with `out_last` set. It sits between the struct assembler and any narrow serial consumer, and decouples their rates.

---
 rtl/struct_pkg.sv | 15 +
 rtl/pair_fifo.sv | 61 ++++++
 rtl/struct_unpacker.sv | 116 +++++++++++
 tb/tb_struct_unpacker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/struct_pkg.sv
// Shared definitions for the {last, first} packed pair word and the beat FSM
// that serialises it.
package struct_pkg;

    localparam int FIELD_W   = 2;
    localparam int FIRST_LSB = 0;
    localparam int LAST_LSB  = FIELD_W;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } beat_state_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO for packed pair words. The read data is the current head,
// so a pop and the capture of that head happen on the same edge.
module pair_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage is not reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/struct_unpacker.sv
// Buffers {last, first} pair words and emits each as two FIELD_W-bit beats,
// first then last (with out_last), on a valid/ready stream.
module struct_unpacker
    import struct_pkg::*;
#(
    parameter  int FIELD_W = struct_pkg::FIELD_W,
    parameter  int DEPTH   = 4,
    localparam int WORD_W  = 2 * FIELD_W,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIELD_W-1:0] out_data,
    output logic              out_last,
    output logic [CW-1:0]     count
);

    localparam int LAST_OFF = FIRST_LSB + FIELD_W;

    beat_state_t       r_state;
    beat_state_t       w_state_nxt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    // in_ready depends only on occupancy; a same-cycle pop never frees a slot.
    assign in_ready = rst_n && !w_full;
    assign w_push   = in_valid && in_ready;

    pair_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_word <= w_head;
            end
        end
    end

    // Emptiness is the registered occupancy, so a word pushed on the same
    // edge that SECOND completes is picked up one cycle later via EMPTY.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = FIRST;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    w_state_nxt = SECOND;
                end
            end
            SECOND: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = FIRST;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (r_state)
            FIRST: begin
                out_valid = 1'b1;
                out_data  = r_word[FIRST_LSB +: FIELD_W];
            end
            SECOND: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = r_word[LAST_OFF +: FIELD_W];
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_struct_unpacker.sv
// Directed bench for struct_unpacker: expected beats are queued on accepted
// pushes and checked in order as the DUT hands them off.
module tb_struct_unpacker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic       out_last;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [2:0] sb [$];   // {last, field}

    logic       prev_stall = 1'b0;
    logic [1:0] prev_data;
    logic       prev_last;

    struct_unpacker #(.FIELD_W(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb.push_back({1'b0, w[1:0]});
            sb.push_back({1'b1, w[3:2]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        tick();
    endtask

    // Handshake monitor and hold-stability check; values seen at the falling
    // edge are the ones the next rising edge acts on.
    always @(negedge clk) begin
        logic [2:0] exp;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'({out_last, out_data}), 32'hFF);
                end else begin
                    exp = sb.pop_front();
                    chk("beat_data", 32'(out_data), 32'(exp[1:0]));
                    chk("beat_last", 32'(out_last), 32'(exp[2]));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single word: beat 0 visible after the second edge
        push_word(4'b1101);
        @(negedge clk);
        chk("lat_count_e0", 32'(count), 32'd1);
        chk("lat_valid_e0", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_beat0", 32'(out_data), 32'b01);
        chk("single_last0", 32'(out_last), 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("single_done_valid", 32'(out_valid), 32'd0);
        chk("single_done_count", 32'(count), 32'd0);
        chk("single_sb", 32'(sb.size()), 32'd0);

        // Fill with out_ready low; second push coincides with a pop at count 1
        tick();
        out_ready = 1'b0;
        push_word(4'h1);
        push_word(4'h6);
        chk("pushpop_cnt1", 32'(count), 32'd1);
        push_word(4'hB);
        push_word(4'hC);
        push_word(4'h3);
        @(negedge clk);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_data", 32'(out_data), 32'h1);
        tick();
        in_valid = 1'b1;
        in_data  = 4'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_count", 32'(count), 32'd4);
        end
        tick();
        in_valid = 1'b0;

        // Back-to-back drain from full
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_last", 32'(out_last), 32'(i % 2));
        end
        @(negedge clk);
        chk("b2b_end_valid", 32'(out_valid), 32'd0);
        chk("b2b_end_count", 32'(count), 32'd0);
        chk("b2b_sb", 32'(sb.size()), 32'd0);

        // Backpressure: toggle out_ready every cycle
        tick();
        out_ready = 1'b0;
        push_word(4'h4);
        push_word(4'hE);
        push_word(4'h7);
        for (int i = 0; i < 16; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        drain(40);
        chk("bp_count", 32'(count), 32'd0);

        // Pointer wrap: 3*DEPTH words with random gaps
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push_word(4'($urandom));
        end
        drain(60);
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_valid", 32'(out_valid), 32'd0);

        // Mid-reset while in SECOND with two words queued
        out_ready = 1'b0;
        push_word(4'h2);
        push_word(4'h8);
        push_word(4'hF);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_in_second", 32'(out_last), 32'd1);
        chk("mid_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        repeat (2) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
